ex_stage: RTL
=============

EX_STAGE -- requirements
Module: ex_stage

Interface
REQ-001 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, asynchronous, active-low.
REQ-003 SHALL have port stall, input, StallBus (6) bits: pipeline stall vector; bit 2 = ID/EX boundary, bit 3 = EX/MEM boundary; Stop=1.
REQ-004 SHALL have port id_to_ex_bus, input, 159 bits, fields from MSB: pc[158:127], inst[126:95], alu_op[94:83], sel_src1[82:80], sel_src2[79:76], ram_en[75], ram_wen[74:71], rf_we[70], rf_waddr[69:65], sel_rf_res[64], rdata1[63:32], rdata2[31:0].
REQ-005 SHALL have port ex_to_mem_bus, output, 82 bits: {pc, opcode[5:0], ram_en, byte_wen[3:0], sel_rf_res, rf_we, rf_waddr, result}.
REQ-006 SHALL have port ex_to_rf_bus, output, 38 bits: {rf_we, rf_waddr, result}, forwarding path to ID.
REQ-007 SHALL have ports data_sram_en (1 bit), data_sram_wen (4 bits), data_sram_addr (32 bits), data_sram_wdata (32 bits), all outputs.
REQ-008 SHALL have port stallreq_ex, output, 1 bit: request to freeze IF/ID/EX while the divider is busy.

Function
REQ-009 SHALL register id_to_ex_bus: clear it when stall[2]=Stop and stall[3]=NoStop (bubble), load it when stall[2]=NoStop, hold it otherwise.
REQ-010 SHALL select src1 as rdata1, pc, or zero-extended inst[10:6]; src2 as rdata2, sign-extended imm, 32'd8, or zero-extended imm, all one-hot per sel fields.
REQ-011 SHALL compute a one-hot 12-op ALU {add, sub, slt, sltu, and, nor, or, xor, sll, srl, sra, lui}; shifts use src1[4:0] as amount on src2; lui = {imm,16'b0}; add/sub wrap mod 2^32, no overflow trap.
REQ-012 SHALL decode from inst: mult, multu, div, divu, mul, mfhi, mflo, mthi, mtlo.
REQ-013 SHALL keep HI/LO registers inside the block; mult/multu write the 64-bit signed/unsigned product {HI,LO} at the end of the EX cycle; mthi/mtlo write rdata1.
REQ-014 SHALL give mfhi/mflo the current HI/LO value; mul's result SHALL be the low 32 bits of the signed product, with HI/LO unchanged.
REQ-015 SHALL implement div/divu as a 32-iteration radix-2 restoring divider on magnitudes, applying sign fixup for div (quotient negative iff signs differ; remainder takes dividend sign).
REQ-016 SHALL have divider FSM states IDLE, RUN, DONE: IDLE->RUN on a div/divu in EX, latching operands; RUN counts 32 cycles then ->DONE; DONE writes LO=quotient, HI=remainder, then ->IDLE.
REQ-017 SHALL assert stallreq_ex combinationally in IDLE when div/divu is present, and throughout RUN; it SHALL be low in DONE, so the divide retires in DONE (34 EX cycles in total).
REQ-018 SHALL produce quotient 32'hFFFF_FFFF and remainder = dividend for a zero divisor, with no trap and the same latency.
REQ-019 SHALL form data_sram_addr as the ALU sum and data_sram_en as ram_en; for sw, wen=4'b1111 and wdata=rdata2.
REQ-020 SHALL, for sh, set wen=4'b0011 or 4'b1100 by addr[1] and replicate rdata2[15:0]; for sb, set wen one-hot by addr[1:0] and replicate rdata2[7:0].
REQ-021 SHALL force data_sram_en and data_sram_wen to 0 while stallreq_ex is high or the stage holds a bubble.
REQ-022 SHALL set result to: the mfhi/mflo value, otherwise the mul product, otherwise the ALU output.

Reset
REQ-023 SHALL, on rst low, asynchronously clear the bus register, HI, LO, divider operands and counter, and force the FSM to IDLE; all outputs SHALL then be 0.
REQ-024 SHALL abort a divide in progress on reset, leaving HI/LO at 0.

Structure
REQ-025 SHALL place the bus widths (159/82/38), StallBus, the Stop/NoStop values and the alu_op bit positions in the shared defines package.
REQ-026 SHALL implement the divider as sub-module div_iter (start, signed, operands, busy/done, quotient, remainder); the multiplier SHALL remain inline.

Verification
REQ-027 SHALL cover: addiu with rdata1=5, imm=0xFFFF -> result 4, rf_we=1.
REQ-028 SHALL cover: div with 0xFFFFFFF9 / 2 -> stallreq_ex high for 33 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF.
REQ-029 SHALL cover: divu by 0 with dividend 7 -> LO=0xFFFFFFFF, HI=7 after 34 cycles.
REQ-030 SHALL cover: sb at addr 0x...2 with rdata2=0xAB -> wen=4'b0100, wdata=0xABABABAB; sh at addr 0x...2 -> wen=4'b1100.
REQ-031 SHALL cover: multu of 0xFFFFFFFF by 2, then mfhi -> HI=1, LO=0xFFFFFFFE, mfhi result 1.
REQ-032 SHALL cover: rst low mid-RUN -> FSM IDLE, stallreq_ex=0, HI=LO=0, outputs 0 immediately.

Source files
------------

// File: rtl/ex_stage_pkg.sv
// ----------------------------------------------------------------------------
// ex_stage_pkg
// Shared definitions for the EX pipeline stage: bus widths, stall vector
// encoding, alu_op one-hot bit positions, source-select bit positions,
// instruction opcodes/functs decoded in EX, the divider state type and the
// store byte-enable helper.
// Ports: none (package).
// ----------------------------------------------------------------------------
package ex_stage_pkg;

    localparam int ID_TO_EX_WD  = 159;
    localparam int EX_TO_MEM_WD = 82;
    localparam int EX_TO_RF_WD  = 38;
    localparam int STALL_BUS    = 6;

    localparam logic STOP    = 1'b1;
    localparam logic NO_STOP = 1'b0;

    // alu_op one-hot positions, MSB first: add sub slt sltu and nor or xor sll srl sra lui
    localparam int ALU_ADD  = 11;
    localparam int ALU_SUB  = 10;
    localparam int ALU_SLT  = 9;
    localparam int ALU_SLTU = 8;
    localparam int ALU_AND  = 7;
    localparam int ALU_NOR  = 6;
    localparam int ALU_OR   = 5;
    localparam int ALU_XOR  = 4;
    localparam int ALU_SLL  = 3;
    localparam int ALU_SRL  = 2;
    localparam int ALU_SRA  = 1;
    localparam int ALU_LUI  = 0;

    localparam int SRC1_RS   = 0;
    localparam int SRC1_PC   = 1;
    localparam int SRC1_SA   = 2;
    localparam int SRC2_RT   = 0;
    localparam int SRC2_SIMM = 1;
    localparam int SRC2_8    = 2;
    localparam int SRC2_ZIMM = 3;

    localparam logic [5:0] OP_SPECIAL  = 6'b000000;
    localparam logic [5:0] OP_SPECIAL2 = 6'b011100;
    localparam logic [5:0] OP_SB       = 6'b101000;
    localparam logic [5:0] OP_SH       = 6'b101001;

    localparam logic [5:0] FN_MFHI  = 6'b010000;
    localparam logic [5:0] FN_MTHI  = 6'b010001;
    localparam logic [5:0] FN_MFLO  = 6'b010010;
    localparam logic [5:0] FN_MTLO  = 6'b010011;
    localparam logic [5:0] FN_MULT  = 6'b011000;
    localparam logic [5:0] FN_MULTU = 6'b011001;
    localparam logic [5:0] FN_DIV   = 6'b011010;
    localparam logic [5:0] FN_DIVU  = 6'b011011;
    localparam logic [5:0] FN_MUL   = 6'b000010;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [11:0] alu_op;
        logic [2:0]  sel_src1;
        logic [3:0]  sel_src2;
        logic        ram_en;
        logic [3:0]  ram_wen;
        logic        rf_we;
        logic [4:0]  rf_waddr;
        logic        sel_rf_res;
        logic [31:0] rdata1;
        logic [31:0] rdata2;
    } id_to_ex_t;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_RUN  = 2'd1,
        DIV_DONE = 2'd2
    } div_state_e;

    // Little-endian byte lanes: sb picks one lane, sh picks a half, anything else is a word.
    function automatic logic [3:0] store_wen(input logic [5:0] opcode, input logic [1:0] addr_lo);
        logic [3:0] wen;
        case (opcode)
            OP_SB:   wen = 4'b0001 << addr_lo;
            OP_SH:   wen = addr_lo[1] ? 4'b1100 : 4'b0011;
            default: wen = 4'b1111;
        endcase
        return wen;
    endfunction

endpackage

// File: rtl/ex_stage_div_iter.sv
// ----------------------------------------------------------------------------
// div_iter
// 32-iteration radix-2 restoring divider on operand magnitudes with sign
// fixup for signed divides.
//
// state | meaning
// IDLE  | waiting for start; operands latched on start
// RUN   | one quotient bit per cycle, 32 cycles (down-counter 31..0)
// DONE  | quotient/remainder valid for one cycle
//
// Ports:
//   clk, rst        clock, async active-low reset
//   start           divide request (honoured only in IDLE)
//   is_signed       1 = div, 0 = divu
//   dividend/divisor operands
//   busy            high in RUN
//   done            high in DONE
//   quotient/remainder  sign-corrected results (valid in DONE)
// ----------------------------------------------------------------------------
module div_iter
    import ex_stage_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        is_signed,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic        busy,
    output logic        done,
    output logic [31:0] quotient,
    output logic [31:0] remainder
);

    div_state_e  state, state_next;
    logic [4:0]  cnt;
    logic [31:0] dsor, rem, quo;
    logic        neg_quo, neg_rem;
    logic [32:0] partial;
    logic        ge;
    logic [31:0] sub_lo;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= DIV_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            DIV_IDLE: if (start) state_next = DIV_RUN;
            DIV_RUN:  if (cnt == 5'd0) state_next = DIV_DONE;
            DIV_DONE: state_next = DIV_IDLE;
            default:  state_next = DIV_IDLE;
        endcase
    end

    // Shift the next dividend bit into the partial remainder; subtract when it fits.
    // The remainder is always below the divisor, so the low 32 bits of the
    // difference are the full new remainder.
    assign partial = {rem, quo[31]};
    assign ge      = (partial >= {1'b0, dsor});
    assign sub_lo  = partial[31:0] - dsor;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt     <= 5'd0;
            dsor    <= 32'd0;
            rem     <= 32'd0;
            quo     <= 32'd0;
            neg_quo <= 1'b0;
            neg_rem <= 1'b0;
        end else if (state == DIV_IDLE && start) begin
            cnt     <= 5'd31;
            rem     <= 32'd0;
            quo     <= (is_signed && dividend[31]) ? (32'd0 - dividend) : dividend;
            dsor    <= (is_signed && divisor[31])  ? (32'd0 - divisor)  : divisor;
            // A zero divisor must give all-ones quotient regardless of signs.
            neg_quo <= is_signed && (dividend[31] ^ divisor[31]) && (divisor != 32'd0);
            neg_rem <= is_signed && dividend[31];
        end else if (state == DIV_RUN) begin
            cnt <= cnt - 5'd1;
            if (ge) begin
                rem <= sub_lo;
                quo <= {quo[30:0], 1'b1};
            end else begin
                rem <= partial[31:0];
                quo <= {quo[30:0], 1'b0};
            end
        end
    end

    assign busy      = (state == DIV_RUN);
    assign done      = (state == DIV_DONE);
    assign quotient  = neg_quo ? (32'd0 - quo) : quo;
    assign remainder = neg_rem ? (32'd0 - rem) : rem;

endmodule

// File: rtl/ex_stage.sv
// ----------------------------------------------------------------------------
// ex_stage
// Execute stage: ID/EX bus register, operand select, one-hot ALU, inline
// multiplier, HI/LO registers, iterative divider, store byte-lane shaping.
//
// Ports:
//   clk, rst          clock, async active-low reset
//   stall             pipeline stall vector (bit2 ID/EX, bit3 EX/MEM, 1 = stop)
//   id_to_ex_bus      decoded instruction from ID
//   ex_to_mem_bus     {pc, opcode, ram_en, byte_wen, sel_rf_res, rf_we, rf_waddr, result}
//   ex_to_rf_bus      {rf_we, rf_waddr, result} forwarding to ID
//   data_sram_*       data memory request
//   stallreq_ex       freeze request while a divide is in flight
// ----------------------------------------------------------------------------
module ex_stage
    import ex_stage_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic [STALL_BUS-1:0]    stall,
    input  logic [ID_TO_EX_WD-1:0]  id_to_ex_bus,
    output logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus,
    output logic [EX_TO_RF_WD-1:0]  ex_to_rf_bus,
    output logic                    data_sram_en,
    output logic [3:0]              data_sram_wen,
    output logic [31:0]             data_sram_addr,
    output logic [31:0]             data_sram_wdata,
    output logic                    stallreq_ex
);

    id_to_ex_t   ex_r;
    logic        ex_valid;
    logic [5:0]  opcode, funct;
    logic        is_special;
    logic        inst_mult, inst_multu, inst_div, inst_divu, inst_mul;
    logic        inst_mfhi, inst_mflo, inst_mthi, inst_mtlo;
    logic [31:0] imm_sext, imm_zext, src1, src2;
    logic [31:0] sum, sub, sra_res, alu_res;
    logic [63:0] prod_s, prod_u;
    logic [31:0] hi, lo, result;
    logic        div_busy, div_done;
    logic [31:0] quotient, remainder;
    logic [3:0]  byte_wen;
    logic [31:0] store_data;
    logic        mem_block;
    logic        unused_bits;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ex_r     <= '0;
            ex_valid <= 1'b0;
        end else if (stall[2] == STOP && stall[3] == NO_STOP) begin
            ex_r     <= '0;
            ex_valid <= 1'b0;
        end else if (stall[2] == NO_STOP) begin
            ex_r     <= id_to_ex_t'(id_to_ex_bus);
            ex_valid <= 1'b1;
        end
    end

    assign opcode     = ex_r.inst[31:26];
    assign funct      = ex_r.inst[5:0];
    assign is_special = (opcode == OP_SPECIAL);
    assign inst_mult  = is_special && funct == FN_MULT;
    assign inst_multu = is_special && funct == FN_MULTU;
    assign inst_div   = is_special && funct == FN_DIV;
    assign inst_divu  = is_special && funct == FN_DIVU;
    assign inst_mfhi  = is_special && funct == FN_MFHI;
    assign inst_mflo  = is_special && funct == FN_MFLO;
    assign inst_mthi  = is_special && funct == FN_MTHI;
    assign inst_mtlo  = is_special && funct == FN_MTLO;
    assign inst_mul   = (opcode == OP_SPECIAL2) && funct == FN_MUL;

    assign imm_sext = {{16{ex_r.inst[15]}}, ex_r.inst[15:0]};
    assign imm_zext = {16'd0, ex_r.inst[15:0]};

    assign src1 = ({32{ex_r.sel_src1[SRC1_RS]}} & ex_r.rdata1)
                | ({32{ex_r.sel_src1[SRC1_PC]}} & ex_r.pc)
                | ({32{ex_r.sel_src1[SRC1_SA]}} & {27'd0, ex_r.inst[10:6]});

    assign src2 = ({32{ex_r.sel_src2[SRC2_RT]}}   & ex_r.rdata2)
                | ({32{ex_r.sel_src2[SRC2_SIMM]}} & imm_sext)
                | ({32{ex_r.sel_src2[SRC2_8]}}    & 32'd8)
                | ({32{ex_r.sel_src2[SRC2_ZIMM]}} & imm_zext);

    assign sum     = src1 + src2;
    assign sub     = src1 - src2;
    assign sra_res = $signed(src2) >>> src1[4:0];

    assign alu_res = ({32{ex_r.alu_op[ALU_ADD]}}  & sum)
                   | ({32{ex_r.alu_op[ALU_SUB]}}  & sub)
                   | ({32{ex_r.alu_op[ALU_SLT]}}  & {31'd0, $signed(src1) < $signed(src2)})
                   | ({32{ex_r.alu_op[ALU_SLTU]}} & {31'd0, src1 < src2})
                   | ({32{ex_r.alu_op[ALU_AND]}}  & (src1 & src2))
                   | ({32{ex_r.alu_op[ALU_NOR]}}  & ~(src1 | src2))
                   | ({32{ex_r.alu_op[ALU_OR]}}   & (src1 | src2))
                   | ({32{ex_r.alu_op[ALU_XOR]}}  & (src1 ^ src2))
                   | ({32{ex_r.alu_op[ALU_SLL]}}  & (src2 << src1[4:0]))
                   | ({32{ex_r.alu_op[ALU_SRL]}}  & (src2 >> src1[4:0]))
                   | ({32{ex_r.alu_op[ALU_SRA]}}  & sra_res)
                   | ({32{ex_r.alu_op[ALU_LUI]}}  & {ex_r.inst[15:0], 16'd0});

    assign prod_s = $signed({{32{ex_r.rdata1[31]}}, ex_r.rdata1})
                  * $signed({{32{ex_r.rdata2[31]}}, ex_r.rdata2});
    assign prod_u = {32'd0, ex_r.rdata1} * {32'd0, ex_r.rdata2};

    div_iter u_div (
        .clk       (clk),
        .rst       (rst),
        .start     (inst_div | inst_divu),
        .is_signed (inst_div),
        .dividend  (ex_r.rdata1),
        .divisor   (ex_r.rdata2),
        .busy      (div_busy),
        .done      (div_done),
        .quotient  (quotient),
        .remainder (remainder)
    );

    // The divide still sits in EX during DONE but must not re-request a stall,
    // so it retires in that cycle.
    assign stallreq_ex = ((inst_div | inst_divu) & ~div_busy & ~div_done) | div_busy;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hi <= 32'd0;
            lo <= 32'd0;
        end else if (div_done) begin
            lo <= quotient;
            hi <= remainder;
        end else if (inst_mult) begin
            {hi, lo} <= prod_s;
        end else if (inst_multu) begin
            {hi, lo} <= prod_u;
        end else begin
            if (inst_mthi) hi <= ex_r.rdata1;
            if (inst_mtlo) lo <= ex_r.rdata1;
        end
    end

    assign result = inst_mfhi ? hi :
                    inst_mflo ? lo :
                    inst_mul  ? prod_s[31:0] :
                                alu_res;

    assign mem_block  = stallreq_ex | ~ex_valid;
    assign byte_wen   = (ex_r.ram_wen != 4'd0) ? store_wen(opcode, sum[1:0]) : 4'd0;
    assign store_data = (opcode == OP_SB) ? {4{ex_r.rdata2[7:0]}}  :
                        (opcode == OP_SH) ? {2{ex_r.rdata2[15:0]}} :
                                            ex_r.rdata2;

    assign data_sram_en    = ex_r.ram_en & ~mem_block;
    assign data_sram_wen   = mem_block ? 4'd0 : byte_wen;
    assign data_sram_addr  = sum;
    assign data_sram_wdata = store_data;

    assign ex_to_mem_bus = {ex_r.pc, opcode, data_sram_en, data_sram_wen, ex_r.sel_rf_res,
                            ex_r.rf_we, ex_r.rf_waddr, result};
    assign ex_to_rf_bus  = {ex_r.rf_we, ex_r.rf_waddr, result};

    assign unused_bits = ^{stall[5:4], stall[1:0], ex_r.inst[25:16]};

endmodule
